// File: rtl/rpspmc_axis_pkg.sv
// Shared helpers for the RPSPMC AXI-Stream blocks: width math and lane sign extension.
package rpspmc_axis_pkg;

  // Widest vector handled by the lane sign-extension helper.
  localparam int unsigned SEXT_W = 64;

  // Ceiling log2, for sizing ports and counters.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: holds 2^max_dec_log2 full-scale samples without overflow.
  function automatic int unsigned acc_width(input int unsigned sig_w, input int unsigned max_d);
    return sig_w + max_d;
  endfunction

  // Sign-extend the low sig_w bits of v to SEXT_W bits; bits above sig_w are ignored.
  function automatic logic [SEXT_W-1:0] sext_lane(input logic [SEXT_W-1:0] v,
                                                  input int unsigned sig_w);
    logic [SEXT_W-1:0] r;
    for (int unsigned i = 0; i < SEXT_W; i++) begin
      r[6'(i)] = (i < sig_w) ? v[6'(i)] : v[6'(sig_w - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/boxcar_lane.sv
// One lane of the boxcar decimator: accumulate samples, then round and shift to the mean.
module boxcar_lane
  import rpspmc_axis_pkg::*;
#(
  parameter int unsigned LANE_WIDTH   = 16,
  parameter int unsigned SIG_WIDTH    = 14,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  parameter int unsigned DLW          = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [LANE_WIDTH-1:0] i_lane,
  input  logic                  i_beat,
  input  logic                  i_first,
  input  logic [DLW-1:0]        i_d,
  output logic [OUT_WIDTH-1:0]  o_mean
);

  localparam int unsigned ACC_W = acc_width(SIG_WIDTH, MAX_DEC_LOG2);

  logic signed [SEXT_W-1:0] w_ext;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_half;
  logic signed [ACC_W-1:0]  w_rnd;

  assign w_ext = sext_lane(SEXT_W'(i_lane), SIG_WIDTH);

  // First beat of a block starts from zero so a discarded partial never leaks in.
  assign w_sum = ACC_W'((i_first ? '0 : SEXT_W'(r_acc)) + w_ext);

  // Half an output LSB for round-half-up; nothing to add at D = 0.
  always_comb begin
    w_half = '0;
    if (i_d != '0) w_half = ACC_W'(1) << (i_d - 1'b1);
  end

  assign w_rnd = w_sum + w_half;

  // The mean always fits SIG_WIDTH, so resizing to OUT_WIDTH preserves the value.
  assign o_mean = OUT_WIDTH'(w_rnd >>> i_d);

  // Running sum, updated on every accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_beat) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/axis_boxcar_decimator.sv
// N-lane accumulate-and-dump decimator with runtime 2^D block length and an AXIS output register.
module axis_boxcar_decimator
  import rpspmc_axis_pkg::*;
#(
  parameter int unsigned NCH          = 2,
  parameter int unsigned LANE_WIDTH   = 16,
  parameter int unsigned SIG_WIDTH    = 14,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  parameter int unsigned DLW          = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NCH*LANE_WIDTH-1:0] S_AXIS_SIGNAL_tdata,
  input  logic                      S_AXIS_SIGNAL_tvalid,
  input  logic [DLW-1:0]            dec_log2,
  input  logic                      restart,
  input  logic                      clear_overrun,
  output logic [NCH*OUT_WIDTH-1:0]  M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic                      overrun,
  output logic [DLW-1:0]            block_d
);

  localparam logic [DLW-1:0] MaxD = DLW'(MAX_DEC_LOG2);

  logic [MAX_DEC_LOG2-1:0]  r_cnt;
  logic [DLW-1:0]           r_d_cur;
  logic [NCH*OUT_WIDTH-1:0] r_tdata;
  logic                     r_tvalid;
  logic                     r_overrun;
  logic [DLW-1:0]           r_block_d;

  logic [DLW-1:0]           w_d_req;
  logic [DLW-1:0]           w_d;
  logic                     w_first;
  logic                     w_beat;
  logic [MAX_DEC_LOG2:0]    w_blk_len;
  logic                     w_last;
  logic                     w_load;
  logic                     w_drop;
  logic [NCH*OUT_WIDTH-1:0] w_mean;

  assign w_d_req   = (dec_log2 > MaxD) ? MaxD : dec_log2;
  assign w_first   = (r_cnt == '0);
  // The block length is fixed by the value latched at the first beat.
  assign w_d       = w_first ? w_d_req : r_d_cur;
  assign w_beat    = S_AXIS_SIGNAL_tvalid & ~restart;
  assign w_blk_len = (MAX_DEC_LOG2 + 1)'(1) << w_d;
  assign w_last    = w_beat && ({1'b0, r_cnt} == (w_blk_len - 1'b1));
  assign w_load    = w_last && (!r_tvalid || M_AXIS_tready);
  assign w_drop    = w_last && r_tvalid && !M_AXIS_tready;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    boxcar_lane #(
      .LANE_WIDTH  (LANE_WIDTH),
      .SIG_WIDTH   (SIG_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .MAX_DEC_LOG2(MAX_DEC_LOG2),
      .DLW         (DLW)
    ) u_lane (
      .i_clk  (aclk),
      .i_rst_n(aresetn),
      .i_lane (S_AXIS_SIGNAL_tdata[k*LANE_WIDTH +: LANE_WIDTH]),
      .i_beat (w_beat),
      .i_first(w_first),
      .i_d    (w_d),
      .o_mean (w_mean[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Beat counter and per-block decimation latch; restart drops any partial block.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt   <= '0;
      r_d_cur <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (S_AXIS_SIGNAL_tvalid) begin
      if (w_first) r_d_cur <= w_d_req;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Single-entry output register; a pending beat is never overwritten while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_block_d <= '0;
    end else if (w_load) begin
      r_tvalid  <= 1'b1;
      r_tdata   <= w_mean;
      r_block_d <= w_d;
    end else if (M_AXIS_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;
  assign overrun       = r_overrun;
  assign block_d       = r_block_d;

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Directed bench for axis_boxcar_decimator with a queue scoreboard of expected output beats.
module tb_axis_boxcar_decimator;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic [3:0]  dec_log2;
  logic        restart;
  logic        clear_overrun;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        overrun;
  logic [3:0]  block_d;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  axis_boxcar_decimator dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .S_AXIS_SIGNAL_tdata (s_tdata),
    .S_AXIS_SIGNAL_tvalid(s_tvalid),
    .dec_log2            (dec_log2),
    .restart             (restart),
    .clear_overrun       (clear_overrun),
    .M_AXIS_tdata        (m_tdata),
    .M_AXIS_tvalid       (m_tvalid),
    .M_AXIS_tready       (m_tready),
    .overrun             (overrun),
    .block_d             (block_d)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rounded mean of a block sum: round half up, arithmetic shift.
  function automatic int mean(input int s, input int d);
    return (s + ((d > 0) ? (1 << (d - 1)) : 0)) >>> d;
  endfunction

  task automatic push_exp(input int m0, input int m1, input int d);
    exp_t e;
    e.data = {16'(m1), 16'(m0)};
    e.d    = 4'(d);
    sb.push_back(e);
  endtask

  // Score any handshake happening at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (m_tvalid && m_tready) begin
      chk("sb_unexpected_out", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_tdata", 64'(m_tdata), 64'(e.data));
        chk("sb_block_d", 64'(block_d), 64'(e.d));
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input int v0, input int v1, input logic [1:0] hi = 2'b00);
    s_tdata  = {hi, 14'(v1), hi, 14'(v0)};
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s0;
    int s1;
    int v0;
    aresetn       = 1'b0;
    s_tdata       = '0;
    s_tvalid      = 1'b0;
    dec_log2      = 4'd0;
    restart       = 1'b0;
    clear_overrun = 1'b0;
    m_tready      = 1'b1;
    #12;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_block_d", 64'(block_d), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(2);

    // 1: D=2 with gaps inside the block.
    dec_log2 = 4'd2;
    beat(1, -1);
    beat(2, -2);
    idle(1);
    beat(3, -3);
    chk("t1_no_early_valid", 64'(m_tvalid), 64'd0);
    idle(2);
    push_exp(mean(10, 2), mean(-10, 2), 2);
    beat(4, -4);
    chk("t1_latency_valid", 64'(m_tvalid), 64'd1);
    chk("t1_lane1_fffe", 64'(m_tdata[31:16]), 64'hfffe);
    idle(2);

    // 2: D=0 passthrough; bits above the significant field ignored.
    dec_log2 = 4'd0;
    push_exp(8191, -8192, 0);
    beat(8191, -8192, 2'b00);
    chk("t2_pass_valid", 64'(m_tvalid), 64'd1);
    push_exp(8191, -8192, 0);
    beat(8191, -8192, 2'b11);
    chk("t2_hi_ignored", 64'(m_tdata), 64'he0001fff);
    push_exp(5, -7, 0);
    beat(5, -7, 2'b10);
    push_exp(-1, 0, 0);
    beat(-1, 0, 2'b01);
    idle(2);

    // 3: D=8 full-scale blocks; mid-block dec_log2 change deferred; clamp above max.
    dec_log2 = 4'd8;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) dec_log2 = 4'd1;
      if (i == 255) push_exp(8191, -8192, 8);
      beat(8191, -8192);
      if (i == 254) chk("t3_still_in_block", 64'(m_tvalid), 64'd0);
    end
    push_exp(mean(-16384, 1), mean(16382, 1), 1);
    beat(-8192, 8191);
    beat(-8192, 8191);
    push_exp(mean(7, 1), mean(-7, 1), 1);
    beat(3, -3);
    beat(4, -4);
    dec_log2 = 4'd15;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 256; i++) begin
      v0 = (i % 7) - 3;
      s0 += v0;
      s1 += -8192 + i;
      if (i == 255) push_exp(mean(s0, 8), mean(s1, 8), 8);
      beat(v0, -8192 + i);
    end
    idle(2);

    // 4: D=1 under backpressure; drops, sticky overrun, set-over-clear, release.
    dec_log2 = 4'd1;
    m_tready = 1'b0;
    push_exp(2, 2, 1);
    beat(1, 1);
    beat(3, 3);
    beat(5, 5);
    chk("t4_no_overrun_yet", 64'(overrun), 64'd0);
    beat(7, 7);
    chk("t4_overrun_set", 64'(overrun), 64'd1);
    chk("t4_tdata_held", 64'(m_tdata), 64'h00020002);
    beat(9, 9);
    clear_overrun = 1'b1;
    beat(11, 11);
    chk("t4_set_wins", 64'(overrun), 64'd1);
    tick();
    clear_overrun = 1'b0;
    chk("t4_overrun_cleared", 64'(overrun), 64'd0);
    chk("t4_still_pending", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    tick();
    chk("t4_single_handshake", 64'(m_tvalid), 64'd0);
    push_exp(2, mean(-4, 1), 1);
    beat(2, -2);
    beat(2, -2);
    idle(2);

    // 5: restart on the last beat kills the block.
    dec_log2 = 4'd2;
    beat(1, -1);
    beat(2, -2);
    beat(3, -3);
    restart = 1'b1;
    beat(4, -4);
    restart = 1'b0;
    chk("t5_no_output", 64'(m_tvalid), 64'd0);
    push_exp(5, mean(-20, 2), 2);
    for (int i = 0; i < 4; i++) beat(5, -5);
    idle(2);

    // 6: async reset mid-block with an output pending and overrun set.
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) beat(1, 1);
    chk("t6_pre_overrun", 64'(overrun), 64'd1);
    chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
    beat(1, 1);
    beat(1, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_async_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_async_overrun", 64'(overrun), 64'd0);
    chk("t6_async_tdata", 64'(m_tdata), 64'd0);
    @(posedge aclk);
    #1;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    push_exp(mean(34, 2), mean(-34, 2), 2);
    beat(7, -7);
    beat(8, -8);
    beat(9, -9);
    beat(10, -10);
    idle(4);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
